// File: rtl/frame_buffer_rwm_if.sv
// Handshake bundle between the frame buffer, its controller/writer (master side)
// and the downstream reader.
interface frame_buffer_rwm_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              enable;
    logic              rw;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              done;

    modport master (
        output enable, rw, clear, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, addr, busy, done
    );

    modport slave (
        input  enable, rw, clear, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, addr, busy, done
    );
endinterface

// File: rtl/frame_buffer_rwm.sv
// Single-frame pixel buffer: streamed write, streamed read through a one-deep
// output register, and a word-per-cycle clear, all abortable by dropping enable.
module frame_buffer_rwm #(
    parameter int DATA_W = 8,
    parameter int IMG_H  = 2,
    parameter int IMG_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    frame_buffer_rwm_if.slave bus
);
    localparam int DEPTH  = IMG_H * IMG_W;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        done_d      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = bus.data_in;
        case (state_q)
            IDLE: begin
                addr_d      = '0;
                out_valid_d = 1'b0;
                data_out_d  = '0;
                if (bus.enable) begin
                    if (bus.clear)   state_d = CLEAR;
                    else if (bus.rw) state_d = WRITE;
                    else             state_d = READ;
                end
            end
            WRITE, CLEAR: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else if (state_q == CLEAR || bus.in_valid) begin
                    mem_we = 1'b1;
                    if (state_q == CLEAR) mem_wdata = '0;
                    if (addr_q == LAST) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            READ: begin
                if (!bus.enable) begin
                    state_d     = IDLE;
                    addr_d      = '0;
                    out_valid_d = 1'b0;
                    data_out_d  = '0;
                end else if (!out_valid_q) begin
                    // first cycle in READ only: prime the output register
                    out_valid_d = 1'b1;
                    data_out_d  = mem[addr_q];
                end else if (bus.out_ready) begin
                    if (addr_q == LAST) begin
                        state_d     = IDLE;
                        addr_d      = '0;
                        out_valid_d = 1'b0;
                        data_out_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        addr_d     = addr_q + ADDR_W'(1);
                        data_out_d = mem[addr_q + ADDR_W'(1)];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            done_q      <= done_d;
        end
    end

    // Storage is deliberately not reset so a partial frame survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= mem_wdata;
    end

    assign bus.in_ready  = (state_q == WRITE) && bus.enable;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.addr      = addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_frame_buffer_rwm.sv
// Directed and randomized bench for frame_buffer_rwm (2x2, 8-bit) against an
// array model of the frame contents.
module tb_frame_buffer_rwm;
    localparam int DATA_W = 8;
    localparam int IMG_H  = 2;
    localparam int IMG_W  = 2;
    localparam int DEPTH  = IMG_H * IMG_W;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] frame   [DEPTH];

    frame_buffer_rwm_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    frame_buffer_rwm #(.DATA_W(DATA_W), .IMG_H(IMG_H), .IMG_W(IMG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input int stall_max, input int fix_idx, input int fix_n);
        int n;
        bus.enable   = 1'b1;
        bus.rw       = 1'b1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("wr_busy", bus.busy, 1);
        for (int i = 0; i < DEPTH; i++) begin
            n = (i == fix_idx) ? fix_n : int'($urandom_range(0, stall_max));
            bus.in_valid = 1'b0;
            for (int s = 0; s < n; s++) begin
                tick();
                check("wr_stall_addr", bus.addr, i);
            end
            bus.in_valid = 1'b1;
            bus.data_in  = frame[i];
            check("wr_in_ready", bus.in_ready, 1);
            check("wr_addr", bus.addr, i);
            check("wr_done_low", bus.done, 0);
            tick();
            ref_mem[i] = frame[i];
        end
        check("wr_done", bus.done, 1);
        check("wr_addr0", bus.addr, 0);
        check("wr_in_ready_idle", bus.in_ready, 0);
        bus.enable   = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("wr_done_pulse", bus.done, 0);
    endtask

    // mode 0: out_ready tied high, 1: pattern 1,0,0,1,0,0..., 2: random
    task automatic read_frame(input int mode);
        int   k   = 0;
        int   cyc = 0;
        int   p   = 0;
        logic rdy;
        bus.enable    = 1'b1;
        bus.rw        = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        check("rd_entry_valid", bus.out_valid, 0);
        check("rd_busy", bus.busy, 1);
        tick();
        while (k < DEPTH && cyc < 60) begin
            check("rd_valid", bus.out_valid, 1);
            check("rd_data", bus.data_out, ref_mem[k]);
            check("rd_done_low", bus.done, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (p % 3 == 0);
                default: rdy = (p >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            tick();
            cyc++;
            if (rdy) begin
                k++;
                p = (mode == 2) ? 0 : p + 1;
            end else begin
                p++;
            end
        end
        check("rd_beats", k, DEPTH);
        if (mode == 0) check("rd_cycles", cyc, DEPTH);
        check("rd_end_valid", bus.out_valid, 0);
        check("rd_end_data", bus.data_out, 0);
        check("rd_done", bus.done, 1);
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        check("rd_done_pulse", bus.done, 0);
        check("rd_idle", bus.busy, 0);
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.rw        = 1'b0;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_data", bus.data_out, 0);
        rst = 1'b0;
        tick();

        // plain write, then write with a 3-cycle stall before the third beat
        frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44;
        write_frame(0, -1, 0);
        frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44;
        write_frame(0, 2, 3);
        read_frame(1);
        read_frame(0);

        // clear wins over rw
        bus.enable = 1'b1;
        bus.clear  = 1'b1;
        bus.rw     = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            check("clr_busy", bus.busy, 1);
            check("clr_addr", bus.addr, i);
            check("clr_in_ready", bus.in_ready, 0);
            check("clr_done_low", bus.done, 0);
            tick();
        end
        check("clr_done", bus.done, 1);
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        bus.rw     = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        tick();
        check("clr_done_pulse", bus.done, 0);
        read_frame(0);

        // abort write after two beats
        bus.enable   = 1'b1;
        bus.rw       = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.data_in = 8'h11;
        tick();
        ref_mem[0] = 8'h11;
        bus.data_in = 8'h22;
        tick();
        ref_mem[1] = 8'h22;
        check("abort_wr_addr", bus.addr, 2);
        bus.enable   = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("abort_wr_done", bus.done, 0);
        check("abort_wr_busy", bus.busy, 0);
        check("abort_wr_addr0", bus.addr, 0);
        check("abort_wr_in_ready", bus.in_ready, 0);

        // reset while the first read beat is presented
        bus.enable    = 1'b1;
        bus.rw        = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_rd_first", bus.data_out, 8'h11);
        rst = 1'b1;
        #2;
        check("rst_rd_busy", bus.busy, 0);
        check("rst_rd_valid", bus.out_valid, 0);
        check("rst_rd_data", bus.data_out, 0);
        check("rst_rd_done", bus.done, 0);
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_rd_done_after", bus.done, 0);
        read_frame(0);

        // randomized frames with random write stalls and read back-pressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) frame[i] = 8'($urandom);
            write_frame(3, -1, 0);
            read_frame(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
